// File: rtl/nn_ctrl_pkg.sv
// Shared types for the MNIST network controller: sequencer state encoding.
package nn_ctrl_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StSrst  = 3'd2,
        StStart = 3'd3,
        StWait  = 3'd4,
        StLoad  = 3'd5,
        StErr   = 3'd6
    } state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter that flags when a neuron-array pass has waited too long.
// With Timeout == 0 the watchdog is disabled and never expires.
module seq_watchdog #(
    parameter int unsigned Timeout = 1024,
    parameter int unsigned Tw      = 11
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (Timeout == 0) begin : g_disabled
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_ni, clr_i, en_i};
        assign expired_o     = 1'b0;
    end else begin : g_enabled
        localparam logic [Tw-1:0] Limit = Tw'(Timeout - 1);

        logic [Tw-1:0] cnt_q, cnt_d;

        // Clear wins over count so each pass starts from zero.
        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = (cnt_q == Limit);
    end

endmodule

// File: rtl/layer_sequencer.sv
// Top-level controller for the MNIST datapath: runs NumLayers neuron-array
// passes (reset, start, wait for done, load result) and pulses ready at the end.
// Outputs are registered from the next-state decode, so they always reflect the
// current state and layer without glitches.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned           NumLayers    = 3,
    parameter int unsigned           Lw           = 2,
    parameter logic [NumLayers-1:0]  InputSelMask = 3'b100,
    parameter int unsigned           Timeout      = 1024,
    parameter int unsigned           Tw           = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 sn_ready_i,
    output logic                 sn_rst_o,
    output logic                 sn_start_o,
    output logic                 shift_en_o,
    output logic                 input_sel_o,
    output logic [Lw-1:0]        weight_sel_o,
    output logic [NumLayers-1:0] ld_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 error_o,
    output logic [Lw-1:0]        layer_o
);

    localparam logic [Lw-1:0] LastLayer = Lw'(NumLayers - 1);

    state_e         state_q, state_d;
    logic [Lw-1:0]  layer_q, layer_d;

    logic                 sn_rst_q, sn_rst_d;
    logic                 sn_start_q, sn_start_d;
    logic                 shift_en_q, shift_en_d;
    logic                 input_sel_q, input_sel_d;
    logic [Lw-1:0]        weight_sel_q, weight_sel_d;
    logic [NumLayers-1:0] ld_q, ld_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    logic wd_expired;

    // Cleared while in SSTART so every WAIT period is timed from zero.
    seq_watchdog #(
        .Timeout (Timeout),
        .Tw      (Tw)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (state_q == StStart),
        .en_i      (state_q == StWait),
        .expired_o (wd_expired)
    );

    // Next-state logic; abort overrides everything except an idle controller.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            layer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) state_d = StArm;
                end
                StArm: begin
                    // The run begins on release of start.
                    if (!start_i) begin
                        state_d = StSrst;
                        layer_d = '0;
                    end
                end
                StSrst:  state_d = StStart;
                StStart: state_d = StWait;
                StWait: begin
                    if (sn_ready_i) begin
                        state_d = StLoad;
                    end else if (wd_expired) begin
                        state_d = StErr;
                    end
                end
                StLoad: begin
                    if (layer_q == LastLayer) begin
                        state_d = StIdle;
                        layer_d = '0;
                    end else begin
                        state_d = StSrst;
                        layer_d = layer_q + 1'b1;
                    end
                end
                StErr: begin
                    if (start_i) state_d = StArm;
                end
                default: begin
                    state_d = StIdle;
                    layer_d = '0;
                end
            endcase
        end
    end

    // Moore decode of the upcoming state and layer, captured into output flops.
    always_comb begin
        sn_rst_d     = (state_d == StSrst);
        sn_start_d   = (state_d == StStart);
        shift_en_d   = state_d inside {StStart, StWait, StLoad};
        busy_d       = !(state_d inside {StIdle, StArm, StErr});
        error_d      = (state_d == StErr);
        ready_d      = (state_d == StLoad) && (layer_d == LastLayer);
        weight_sel_d = '0;
        input_sel_d  = 1'b0;
        ld_d         = '0;
        if (state_d inside {StStart, StWait}) begin
            weight_sel_d = layer_d;
        end
        // Compare against each valid index so unused layer codes decode to nothing.
        for (int i = 0; i < NumLayers; i++) begin
            if (layer_d == Lw'(i)) begin
                if (state_d inside {StStart, StWait}) input_sel_d = InputSelMask[i];
                if (state_d == StLoad) ld_d[i] = 1'b1;
            end
        end
    end

    // State, layer index and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            layer_q      <= '0;
            sn_rst_q     <= 1'b0;
            sn_start_q   <= 1'b0;
            shift_en_q   <= 1'b0;
            input_sel_q  <= 1'b0;
            weight_sel_q <= '0;
            ld_q         <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            sn_rst_q     <= sn_rst_d;
            sn_start_q   <= sn_start_d;
            shift_en_q   <= shift_en_d;
            input_sel_q  <= input_sel_d;
            weight_sel_q <= weight_sel_d;
            ld_q         <= ld_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign sn_rst_o     = sn_rst_q;
    assign sn_start_o   = sn_start_q;
    assign shift_en_o   = shift_en_q;
    assign input_sel_o  = input_sel_q;
    assign weight_sel_o = weight_sel_q;
    assign ld_o         = ld_q;
    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign error_o      = error_q;
    assign layer_o      = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three configurations share one stimulus stream
// (default, short watchdog, five layers) and are checked against a pass-level model
// every cycle, plus directed literal expectations from hand-worked timelines.
module tb_layer_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sn_ready = 1'b1;

    always #5 clk = ~clk;

    // Config 0: defaults.
    logic       a_sn_rst, a_sn_start, a_shift_en, a_input_sel, a_ready, a_busy, a_error;
    logic [1:0] a_weight_sel, a_layer;
    logic [2:0] a_ld;
    // Config 1: Timeout = 8.
    logic       t_sn_rst, t_sn_start, t_shift_en, t_input_sel, t_ready, t_busy, t_error;
    logic [1:0] t_weight_sel, t_layer;
    logic [2:0] t_ld;
    // Config 2: five layers, mask 10011.
    logic       f_sn_rst, f_sn_start, f_shift_en, f_input_sel, f_ready, f_busy, f_error;
    logic [2:0] f_weight_sel, f_layer;
    logic [4:0] f_ld;

    layer_sequencer dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .sn_ready_i(sn_ready),
        .sn_rst_o(a_sn_rst), .sn_start_o(a_sn_start), .shift_en_o(a_shift_en),
        .input_sel_o(a_input_sel), .weight_sel_o(a_weight_sel), .ld_o(a_ld),
        .ready_o(a_ready), .busy_o(a_busy), .error_o(a_error), .layer_o(a_layer)
    );

    layer_sequencer #(.Timeout(8)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .sn_ready_i(sn_ready),
        .sn_rst_o(t_sn_rst), .sn_start_o(t_sn_start), .shift_en_o(t_shift_en),
        .input_sel_o(t_input_sel), .weight_sel_o(t_weight_sel), .ld_o(t_ld),
        .ready_o(t_ready), .busy_o(t_busy), .error_o(t_error), .layer_o(t_layer)
    );

    layer_sequencer #(.NumLayers(5), .Lw(3), .InputSelMask(5'b10011)) dut_f (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .sn_ready_i(sn_ready),
        .sn_rst_o(f_sn_rst), .sn_start_o(f_sn_start), .shift_en_o(f_shift_en),
        .input_sel_o(f_input_sel), .weight_sel_o(f_weight_sel), .ld_o(f_ld),
        .ready_o(f_ready), .busy_o(f_busy), .error_o(f_error), .layer_o(f_layer)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- pass-level model ----------------
    // mode: 0 idle, 1 armed, 2 running a layer pass, 3 timed out.
    // step within a pass: 0 reset, 1 start, 2 waiting, 3 loading.
    localparam int CfgN    [3] = '{3, 3, 5};
    localparam int CfgT    [3] = '{1024, 8, 1024};
    localparam int CfgMask [3] = '{4, 4, 19};

    int m_mode [3];
    int m_lay  [3];
    int m_step [3];
    int m_wait [3];

    always @(posedge clk or negedge rst_n) begin
        for (int c = 0; c < 3; c++) begin
            if (!rst_n) begin
                m_mode[c] = 0; m_lay[c] = 0; m_step[c] = 0; m_wait[c] = 0;
            end else if (abort && m_mode[c] != 0) begin
                m_mode[c] = 0; m_lay[c] = 0;
            end else if (m_mode[c] == 0) begin
                if (start) m_mode[c] = 1;
            end else if (m_mode[c] == 3) begin
                if (start) m_mode[c] = 1;
            end else if (m_mode[c] == 1) begin
                if (!start) begin m_mode[c] = 2; m_lay[c] = 0; m_step[c] = 0; end
            end else if (m_step[c] == 0) begin
                m_step[c] = 1;
            end else if (m_step[c] == 1) begin
                m_step[c] = 2; m_wait[c] = 1;
            end else if (m_step[c] == 2) begin
                // m_wait = number of WAIT cycles elapsed including this one
                if (sn_ready) m_step[c] = 3;
                else if (CfgT[c] != 0 && m_wait[c] >= CfgT[c]) m_mode[c] = 3;
                else m_wait[c]++;
            end else begin
                if (m_lay[c] < CfgN[c] - 1) begin m_lay[c]++; m_step[c] = 0; end
                else begin m_mode[c] = 0; m_lay[c] = 0; end
            end
        end
    end

    task automatic cmp(input int c, input int srst, input int sst, input int sh, input int isel,
                       input int wsel, input int ld, input int rdy, input int bsy, input int err,
                       input int lay);
        bit run, act;
        int s, l;
        run = (m_mode[c] == 2);
        s   = m_step[c];
        l   = m_lay[c];
        act = run && (s == 1 || s == 2);
        chk($sformatf("cfg%0d snRst", c), srst, int'(run && s == 0));
        chk($sformatf("cfg%0d snStart", c), sst, int'(run && s == 1));
        chk($sformatf("cfg%0d shiftEn", c), sh, int'(run && s != 0));
        chk($sformatf("cfg%0d inputSel", c), isel, act ? ((CfgMask[c] >> l) & 1) : 0);
        chk($sformatf("cfg%0d weightSel", c), wsel, act ? l : 0);
        chk($sformatf("cfg%0d ld", c), ld, (run && s == 3) ? (1 << l) : 0);
        chk($sformatf("cfg%0d ready", c), rdy, int'(run && s == 3 && l == CfgN[c] - 1));
        chk($sformatf("cfg%0d busy", c), bsy, int'(run));
        chk($sformatf("cfg%0d error", c), err, int'(m_mode[c] == 3));
        chk($sformatf("cfg%0d layer", c), lay, l);
    endtask

    always @(negedge clk) begin
        cmp(0, int'(a_sn_rst), int'(a_sn_start), int'(a_shift_en), int'(a_input_sel),
            int'(a_weight_sel), int'(a_ld), int'(a_ready), int'(a_busy), int'(a_error),
            int'(a_layer));
        cmp(1, int'(t_sn_rst), int'(t_sn_start), int'(t_shift_en), int'(t_input_sel),
            int'(t_weight_sel), int'(t_ld), int'(t_ready), int'(t_busy), int'(t_error),
            int'(t_layer));
        cmp(2, int'(f_sn_rst), int'(f_sn_start), int'(f_shift_en), int'(f_input_sel),
            int'(f_weight_sel), int'(f_ld), int'(f_ready), int'(f_busy), int'(f_error),
            int'(f_layer));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise start for n cycles and release; caller's next negedge is cycle 0.
    task automatic start_pulse(input int n);
        start = 1'b1;
        cyc(n);
        start = 1'b0;
    endtask

    int ld1_pulses;
    int ready_pulses;

    initial begin
        #13 rst_n = 1'b1;
        cyc(2);
        chk("reset busy", int'(a_busy), 0);
        chk("reset layer", int'(a_layer), 0);
        chk("reset ld", int'(a_ld), 0);

        // Run 1: snReady tied high; start re-raised mid-run must be ignored.
        start_pulse(3);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("run1 snRst k%0d", k), int'(a_sn_rst), int'(k == 1 || k == 5 || k == 9));
            chk($sformatf("run1 ld k%0d", k), int'(a_ld),
                (k == 4) ? 1 : (k == 8) ? 2 : (k == 12) ? 4 : 0);
            chk($sformatf("run1 ready k%0d", k), int'(a_ready), int'(k == 12));
            chk($sformatf("run1 5L ld k%0d", k), int'(f_ld),
                (k % 4 == 0 && k >= 4 && k <= 20) ? (1 << (k / 4 - 1)) : 0);
            chk($sformatf("run1 5L ready k%0d", k), int'(f_ready), int'(k == 20));
            if (k == 3 || k == 7 || k == 10 || k == 11)
                chk($sformatf("run1 inputSel k%0d", k), int'(a_input_sel), int'(k >= 10));
            if (k % 4 == 3)
                chk($sformatf("run1 5L inputSel k%0d", k), int'(f_input_sel),
                    int'(k == 3 || k == 7 || k == 19));
            if (k == 4) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
        cyc(4);

        // Run 2: snReady low through 20 WAIT cycles of layer 1; short watchdog errors.
        start_pulse(2);
        ld1_pulses = 0;
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k == 5) sn_ready = 1'b0;
            if (k == 26) sn_ready = 1'b1;
            if (a_ld[1]) ld1_pulses++;
            if (k >= 7 && k <= 26) begin
                chk($sformatf("run2 shiftEn k%0d", k), int'(a_shift_en), 1);
                chk($sformatf("run2 weightSel k%0d", k), int'(a_weight_sel), 1);
            end
            if (k == 30 || k == 31) chk($sformatf("run2 ready k%0d", k), int'(a_ready), int'(k == 31));
            if (k == 14 || k == 15) chk($sformatf("run2 T8 error k%0d", k), int'(t_error), int'(k == 15));
            if (k == 15) chk("run2 T8 busy in ERR", int'(t_busy), 0);
            if (k == 39) chk("run2 5L ready", int'(f_ready), 1);
        end
        chk("run2 ld1 pulse count", ld1_pulses, 1);
        cyc(3);

        // Run 3: start leaves ERR, error clears, normal run completes.
        chk("run3 T8 error before start", int'(t_error), 1);
        start_pulse(2);
        chk("run3 T8 error cleared", int'(t_error), 0);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 4 || k == 12) chk($sformatf("run3 T8 ld k%0d", k), int'(t_ld), (k == 4) ? 1 : 4);
            if (k == 12) chk("run3 T8 ready", int'(t_ready), 1);
        end
        cyc(10);

        // Run 4: abort in layer 1 WAIT together with snReady.
        start_pulse(1);
        ready_pulses = 0;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (a_ready) ready_pulses++;
            if (k == 7) begin
                chk("run4 weightSel before abort", int'(a_weight_sel), 1);
                abort = 1'b1;
            end
            if (k == 8) begin
                abort = 1'b0;
                chk("run4 busy after abort", int'(a_busy), 0);
                chk("run4 layer after abort", int'(a_layer), 0);
                chk("run4 ld after abort", int'(a_ld), 0);
            end
        end
        chk("run4 ready count", ready_pulses, 0);

        // Run 5: asynchronous reset mid-WAIT of layer 2.
        start_pulse(2);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 9) sn_ready = 1'b0;
        end
        chk("run5 layer in WAIT", int'(a_layer), 2);
        chk("run5 shiftEn in WAIT", int'(a_shift_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("run5 outputs after async reset",
            int'({a_sn_rst, a_sn_start, a_shift_en, a_input_sel, a_weight_sel, a_ld, a_ready,
                  a_busy, a_error, a_layer}), 0);
        sn_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(5);
        chk("run5 idle busy", int'(a_busy), 0);
        chk("run5 idle snRst", int'(a_sn_rst), 0);
        start_pulse(2);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) chk("run5 resume snRst", int'(a_sn_rst), 1);
            if (k == 12) chk("run5 resume ready", int'(a_ready), 1);
        end
        cyc(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
